uart_word_encoder: RTL and testbench

UART_WORD_ENCODER -- requirements
Module: uart_word_encoder

---
 rtl/uart_word_encoder.sv | 152 +++++++++++++++
 tb/tb_uart_word_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_encoder.sv
// uart_word_encoder: turns a 34-bit command/data word into an ASCII line
// (command char, hex digits, terminator) paced for a UART transmitter.
module uart_word_encoder #(
  parameter logic [7:0] TERM_CHAR      = 8'h0A,
  parameter bit         SUPPRESS_ZEROS = 1'b1
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        i_stb,
  input  logic [33:0] i_word,
  output logic        o_busy,
  output logic        o_drop,
  output logic        o_stb,
  output logic [7:0]  o_byte,
  input  logic        i_tx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DIGIT,
    TERM
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cmd_q;
  logic [31:0] data_q;
  logic [2:0]  idx_q;
  logic [2:0]  idx_nxt;
  logic        stb_q;
  logic [7:0]  byte_q;
  logic        drop_q;
  logic        accept;
  logic        issue;
  logic        stb;
  logic [7:0]  cur_byte;
  logic [3:0]  nib;

  function automatic logic [7:0] cmd_char(input logic [1:0] c);
    logic [7:0] r;
    case (c)
      2'b00:   r = 8'h52;
      2'b01:   r = 8'h57;
      2'b10:   r = 8'h41;
      default: r = 8'h53;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) r = 8'h30 + {4'h0, n};
    else           r = 8'h57 + {4'h0, n};
    return r;
  endfunction

  // Index of the first digit to print: top nonzero nibble, never below 0.
  function automatic logic [2:0] start_idx(input logic [31:0] d);
    logic [2:0] r;
    r = 3'd0;
    if (!SUPPRESS_ZEROS) begin
      r = 3'd7;
    end else begin
      for (int i = 1; i < 8; i++) begin
        if (d[4*i +: 4] != 4'h0) r = 3'(i);
      end
    end
    return r;
  endfunction

  assign accept = i_stb && (state == IDLE);
  assign issue  = !i_tx_busy && !stb_q;
  assign nib    = data_q[{idx_q, 2'b00} +: 4];

  // Next-state, digit index and current byte selection.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    stb       = 1'b0;
    cur_byte  = 8'h00;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CMD;
          idx_nxt   = start_idx(i_word[31:0]);
        end
      end
      CMD: begin
        cur_byte = cmd_char(cmd_q);
        stb      = issue;
        if (issue) state_nxt = DIGIT;
      end
      DIGIT: begin
        cur_byte = hex_char(nib);
        stb      = issue;
        if (issue) begin
          if (idx_q == 3'd0) state_nxt = TERM;
          else               idx_nxt   = idx_q - 3'd1;
        end
      end
      TERM: begin
        cur_byte = TERM_CHAR;
        stb      = issue;
        if (issue) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, index and strobe history registers.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx_q <= 3'd0;
      stb_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      stb_q <= stb;
    end
  end

  // Capture the word only when it is accepted.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      cmd_q  <= 2'b00;
      data_q <= 32'h0;
    end else if (accept) begin
      cmd_q  <= i_word[33:32];
      data_q <= i_word[31:0];
    end
  end

  // Hold the last issued byte between strobes.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst)      byte_q <= 8'h00;
    else if (stb) byte_q <= cur_byte;
  end

  // Flag a word offered while one is in flight.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= i_stb && (state != IDLE);
  end

  assign o_busy = (state != IDLE);
  assign o_drop = drop_q;
  assign o_stb  = stb;
  assign o_byte = stb ? cur_byte : byte_q;

endmodule

// File: tb/tb_uart_word_encoder.sv
// tb_uart_word_encoder: directed vectors with a byte scoreboard
// for the default build and a no-suppression build.
module tb_uart_word_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb0;
  logic        stb1;
  logic [33:0] word;
  logic        tx_busy;
  logic        busy0, drop0, ostb0;
  logic [7:0]  byte0;
  logic        busy1, drop1, ostb1;
  logic [7:0]  byte1;

  int errors = 0;
  int checks = 0;
  int stb_cnt0 = 0;
  int drop_cnt0 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] last0, last1;
  logic       prev0, prev1;

  always #5 clk = ~clk;

  uart_word_encoder dut0 (
    .i_clk(clk), .rst(rst), .i_stb(stb0), .i_word(word),
    .o_busy(busy0), .o_drop(drop0), .o_stb(ostb0),
    .o_byte(byte0), .i_tx_busy(tx_busy)
  );

  uart_word_encoder #(.TERM_CHAR(8'h0A), .SUPPRESS_ZEROS(1'b0)) dut1 (
    .i_clk(clk), .rst(rst), .i_stb(stb1), .i_word(word),
    .o_busy(busy1), .o_drop(drop1), .o_stb(ostb1),
    .o_byte(byte1), .i_tx_busy(tx_busy)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor for the default build.
  always @(negedge clk) begin
    if (rst) begin
      last0 = 8'h00;
      prev0 = 1'b0;
    end else begin
      if (ostb0) begin
        if (q0.size() == 0) chk("unexpected_byte0", {24'h0, byte0}, 32'hFFFF);
        else                chk("byte0", {24'h0, byte0}, {24'h0, q0.pop_front()});
        chk("spacing0", {31'h0, prev0}, 0);
        chk("stb_while_txbusy0", {31'h0, tx_busy}, 0);
        stb_cnt0++;
        last0 = byte0;
      end else begin
        chk("hold0", {24'h0, byte0}, {24'h0, last0});
      end
      if (drop0) drop_cnt0++;
      prev0 = ostb0;
    end
  end

  // Monitor for the no-suppression build.
  always @(negedge clk) begin
    if (rst) begin
      last1 = 8'h00;
      prev1 = 1'b0;
    end else begin
      if (ostb1) begin
        if (q1.size() == 0) chk("unexpected_byte1", {24'h0, byte1}, 32'hFFFF);
        else                chk("byte1", {24'h0, byte1}, {24'h0, q1.pop_front()});
        chk("spacing1", {31'h0, prev1}, 0);
        last1 = byte1;
      end else begin
        chk("hold1", {24'h0, byte1}, {24'h0, last1});
      end
      prev1 = ostb1;
    end
  end

  task automatic send(input int sel, input logic [33:0] w);
    @(posedge clk); #1;
    word = w;
    if (sel == 0) stb0 = 1'b1;
    else          stb1 = 1'b1;
    @(posedge clk); #1;
    stb0 = 1'b0;
    stb1 = 1'b0;
  endtask

  task automatic push0(input logic [7:0] b[]);
    foreach (b[i]) q0.push_back(b[i]);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy0 && !busy1 && q0.size() == 0 && q1.size() == 0) return;
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_stb(input int target, input string name);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (stb_cnt0 >= target) return;
    end
    chk({name, "_timeout"}, stb_cnt0, target);
  endtask

  initial begin
    int d;
    rst = 1'b1; stb0 = 1'b0; stb1 = 1'b0;
    word = '0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy0}, 0);
    chk("rst_stb", {31'h0, ostb0}, 0);
    chk("rst_byte", {24'h0, byte0}, 0);
    chk("rst_drop", {31'h0, drop0}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1A3F write with exact cycle pattern.
    push0('{8'h57, 8'h31, 8'h61, 8'h33, 8'h66, 8'h0A});
    send(0, {2'b01, 32'h00001A3F});
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("pattern_stb", {31'h0, ostb0}, (k % 2 == 0) ? 1 : 0);
      chk("pattern_busy", {31'h0, busy0}, 1);
    end
    @(negedge clk);
    chk("busy_after_term", {31'h0, busy0}, 0);
    wait_done("w1a3f");

    // Zero data gives a single digit.
    push0('{8'h52, 8'h30, 8'h0A});
    send(0, {2'b00, 32'h0});
    wait_done("zero");

    // Full eight digits when suppression is off.
    q1.push_back(8'h41);
    for (int i = 0; i < 7; i++) q1.push_back(8'h30);
    q1.push_back(8'h31);
    q1.push_back(8'h0A);
    send(1, {2'b10, 32'h00000001});
    wait_done("nosup");

    // Transmitter stall after the first byte.
    push0('{8'h57, 8'h31, 8'h61, 8'h33, 8'h66, 8'h0A});
    d = stb_cnt0;
    send(0, {2'b01, 32'h00001A3F});
    wait_stb(d + 1, "stall_first");
    tx_busy = 1'b1;
    repeat (10) @(posedge clk);
    chk("stall_hold", {24'h0, byte0}, 32'h57);
    chk("stall_count", stb_cnt0 - d, 1);
    #1 tx_busy = 1'b0;
    wait_done("stall");

    // Word offered while busy is dropped.
    push0('{8'h57, 8'h31, 8'h61, 8'h33, 8'h66, 8'h0A});
    d = drop_cnt0;
    send(0, {2'b01, 32'h00001A3F});
    send(0, {2'b00, 32'hFFFFFFFF});
    wait_done("drop");
    chk("drop_pulses", drop_cnt0 - d, 1);

    // Back-to-back words in the cycle busy falls.
    push0('{8'h52, 8'h30, 8'h0A, 8'h53, 8'h61, 8'h0A});
    d = drop_cnt0;
    send(0, {2'b00, 32'h0});
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!busy0) break;
    end
    word = {2'b11, 32'hA};
    stb0 = 1'b1;
    @(posedge clk); #1;
    stb0 = 1'b0;
    chk("b2b_accept", {31'h0, busy0}, 1);
    wait_done("b2b");
    chk("b2b_no_drop", drop_cnt0 - d, 0);

    // Reset mid-word, then a fresh word.
    push0('{8'h57, 8'h31, 8'h61});
    d = stb_cnt0;
    send(0, {2'b01, 32'h00001A3F});
    wait_stb(d + 3, "midrst");
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, busy0}, 0);
    chk("midrst_stb", {31'h0, ostb0}, 0);
    chk("midrst_byte", {24'h0, byte0}, 0);
    chk("midrst_drop", {31'h0, drop0}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push0('{8'h53, 8'h66, 8'h0A});
    send(0, {2'b11, 32'h0000000F});
    wait_done("after_rst");

    repeat (4) @(posedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
